// File: rtl/reg_write_queue_if.sv
// reg_write_queue_if: writeback, multdiv, regfile-write and bypass signals of reg_write_queue.
// master is the pipeline side, slave is the queue.
interface reg_write_queue_if #(
    parameter int DEPTH = 4
);
    logic                     wb_valid;
    logic [4:0]               wb_reg;
    logic [31:0]              wb_data;
    logic                     md_valid;
    logic                     md_ready;
    logic [4:0]               md_reg;
    logic [31:0]              md_data;
    logic                     ctrl_writeEnable;
    logic [4:0]               ctrl_writeReg;
    logic [31:0]              data_writeReg;
    logic [4:0]               rd_reg_a;
    logic [4:0]               rd_reg_b;
    logic                     byp_hit_a;
    logic                     byp_hit_b;
    logic [31:0]              byp_data_a;
    logic [31:0]              byp_data_b;
    logic [$clog2(DEPTH):0]   queue_count;

    modport master (
        output wb_valid, wb_reg, wb_data, md_valid, md_reg, md_data, rd_reg_a, rd_reg_b,
        input  md_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        input  byp_hit_a, byp_hit_b, byp_data_a, byp_data_b, queue_count
    );
    modport slave (
        input  wb_valid, wb_reg, wb_data, md_valid, md_reg, md_data, rd_reg_a, rd_reg_b,
        output md_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        output byp_hit_a, byp_hit_b, byp_data_a, byp_data_b, queue_count
    );
endinterface

// File: rtl/reg_write_queue.sv
// reg_write_queue: merges pipeline writeback and queued multdiv results into one regfile write port.
// Define REGWQ_BYPASS_EN to build the read-port bypass of pending writes; otherwise bypass outputs are 0.
module reg_write_queue #(
    parameter int DEPTH = 4
) (
    input logic           clock,
    input logic           ctrl_reset,
    reg_write_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    ent_reg_q [DEPTH];
    logic [4:0]    ent_reg_d [DEPTH];
    logic [31:0]   ent_data_q [DEPTH];
    logic [31:0]   ent_data_d [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wen_q, wen_d;
    logic [4:0]    wreg_q, wreg_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          wb_act, full, empty, enq, pop, head_live;

    assign wb_act    = bus.wb_valid && bus.wb_reg != 5'd0;
    assign full      = count_q == CW'(DEPTH);
    assign empty     = count_q == '0;
    assign enq       = bus.md_valid && bus.md_ready && bus.md_reg != 5'd0;
    assign pop       = !wb_act && !empty;
    assign head_live = live_q[rptr_q];

    assign bus.md_ready         = !ctrl_reset && !full;
    assign bus.ctrl_writeEnable = wen_q;
    assign bus.ctrl_writeReg    = wreg_q;
    assign bus.data_writeReg    = wdata_q;
    assign bus.queue_count      = count_q;

    always_comb begin
        ent_reg_d  = ent_reg_q;
        ent_data_d = ent_data_q;
        live_d     = live_q;
        for (int i = 0; i < DEPTH; i++)
            if (wb_act && ent_reg_q[i] == bus.wb_reg) live_d[i] = 1'b0;
        if (pop) live_d[rptr_q] = 1'b0;
        // a same-cycle md write to the wb register is older than wb, so it is stored dead
        if (enq) begin
            ent_reg_d[wptr_q]  = bus.md_reg;
            ent_data_d[wptr_q] = bus.md_data;
            live_d[wptr_q]     = !(wb_act && bus.md_reg == bus.wb_reg);
        end
        wptr_d  = wptr_q + AW'(enq);
        rptr_d  = rptr_q + AW'(pop);
        count_d = count_q + CW'(enq) - CW'(pop);
        wen_d   = wb_act || (pop && head_live);
        wreg_d  = wb_act ? bus.wb_reg : (pop && head_live) ? ent_reg_q[rptr_q] : wreg_q;
        wdata_d = wb_act ? bus.wb_data : (pop && head_live) ? ent_data_q[rptr_q] : wdata_q;
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            live_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            wen_q   <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
        end else begin
            ent_reg_q  <= ent_reg_d;
            ent_data_q <= ent_data_d;
            live_q     <= live_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            wen_q      <= wen_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
        end
    end

`ifdef REGWQ_BYPASS_EN
    logic [4:0]    rd_addr [2];
    logic          hit [2];
    logic [31:0]   hdata [2];
    logic [AW-1:0] idx;

    assign rd_addr[0] = bus.rd_reg_a;
    assign rd_addr[1] = bus.rd_reg_b;

    // scan oldest to newest so the newest live match wins over older ones and the output stage
    always_comb begin
        idx = '0;
        for (int p = 0; p < 2; p++) begin
            hit[p]   = wen_q && wreg_q == rd_addr[p];
            hdata[p] = wdata_q;
            for (int k = 0; k < DEPTH; k++) begin
                idx = rptr_q + AW'(k);
                if (live_q[idx] && ent_reg_q[idx] == rd_addr[p]) begin
                    hit[p]   = 1'b1;
                    hdata[p] = ent_data_q[idx];
                end
            end
            hit[p]   = hit[p] && rd_addr[p] != 5'd0;
            hdata[p] = hit[p] ? hdata[p] : '0;
        end
    end

    assign bus.byp_hit_a  = hit[0];
    assign bus.byp_hit_b  = hit[1];
    assign bus.byp_data_a = hdata[0];
    assign bus.byp_data_b = hdata[1];
`else
    logic unused_rd;
    assign unused_rd      = ^{bus.rd_reg_a, bus.rd_reg_b};
    assign bus.byp_hit_a  = 1'b0;
    assign bus.byp_hit_b  = 1'b0;
    assign bus.byp_data_a = '0;
    assign bus.byp_data_b = '0;
`endif
endmodule

// File: tb/tb_reg_write_queue.sv
// tb_reg_write_queue: vector table, corner sequences and random traffic against a queue model
// with a write scoreboard.
module tb_reg_write_queue;
    localparam int DEPTH = 4;
`ifdef REGWQ_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    typedef struct { logic [4:0] r; logic [31:0] d; logic live; } ent_t;
    typedef struct { logic [4:0] r; logic [31:0] d; } wr_t;
    typedef struct {
        logic r; logic wv; logic [4:0] wr; logic [31:0] wd;
        logic mv; logic [4:0] mr; logic [31:0] md; logic [4:0] ra;
        logic en; logic [4:0] wreg; logic [31:0] wdata; int cnt;
    } vec_t;

    logic clk = 1'b0;
    logic ctrl_reset;
    int n_cmp = 0;
    int n_bad = 0;

    ent_t mq[$];
    wr_t  sb[$];
    logic        m_en;
    logic [4:0]  m_reg;
    logic [31:0] m_data;

    reg_write_queue_if #(.DEPTH(DEPTH)) bus();
    reg_write_queue #(.DEPTH(DEPTH)) dut (.clock(clk), .ctrl_reset(ctrl_reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
        end
    endtask

    task automatic model_byp(input logic [4:0] a, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = '0;
        if (BYP && a != 5'd0) begin
            if (m_en && m_reg == a) begin h = 1'b1; d = m_data; end
            foreach (mq[i]) if (mq[i].live && mq[i].r == a) begin h = 1'b1; d = mq[i].d; end
        end
    endtask

    task automatic step(input logic r, input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                        input logic mv, input logic [4:0] mr, input logic [31:0] md,
                        input logic [4:0] ra, input logic [4:0] rb);
        logic h, wa, acc;
        logic [31:0] d;
        ent_t hd, ne;
        wr_t w;
        @(negedge clk);
        ctrl_reset = r;
        bus.wb_valid = wv; bus.wb_reg = wr; bus.wb_data = wd;
        bus.md_valid = mv; bus.md_reg = mr; bus.md_data = md;
        bus.rd_reg_a = ra; bus.rd_reg_b = rb;
        #1;
        acc = !r && (mq.size() < DEPTH);
        chk("md_ready", 32'(bus.md_ready), 32'(acc));
        model_byp(ra, h, d);
        chk("byp_hit_a", 32'(bus.byp_hit_a), 32'(h));
        chk("byp_data_a", bus.byp_data_a, d);
        model_byp(rb, h, d);
        chk("byp_hit_b", 32'(bus.byp_hit_b), 32'(h));
        chk("byp_data_b", bus.byp_data_b, d);
        wa = wv && wr != 5'd0;
        if (r) begin
            mq.delete(); sb.delete();
            m_en = 1'b0; m_reg = '0; m_data = '0;
        end else begin
            if (wa) foreach (mq[i]) if (mq[i].r == wr) mq[i].live = 1'b0;
            if (wa) begin
                m_en = 1'b1; m_reg = wr; m_data = wd;
                w.r = wr; w.d = wd; sb.push_back(w);
            end else if (mq.size() > 0) begin
                hd = mq.pop_front();
                m_en = hd.live;
                if (hd.live) begin
                    m_reg = hd.r; m_data = hd.d;
                    w.r = hd.r; w.d = hd.d; sb.push_back(w);
                end
            end else m_en = 1'b0;
            if (mv && acc && mr != 5'd0) begin
                ne.r = mr; ne.d = md; ne.live = !(wa && mr == wr);
                mq.push_back(ne);
            end
        end
        @(posedge clk);
        #1;
        chk("enable", 32'(bus.ctrl_writeEnable), 32'(m_en));
        chk("write_reg", 32'(bus.ctrl_writeReg), 32'(m_reg));
        chk("write_data", bus.data_writeReg, m_data);
        chk("count", 32'(bus.queue_count), 32'(mq.size()));
        if (bus.ctrl_writeEnable) begin
            chk("sb_has_write", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                w = sb.pop_front();
                chk("sb_reg", 32'(bus.ctrl_writeReg), 32'(w.r));
                chk("sb_data", bus.data_writeReg, w.d);
            end
        end
    endtask

    task automatic idle(input logic [4:0] ra);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ra, 5'd0);
    endtask

    vec_t vt[10];

    initial begin
        vt[0] = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    5'd0, 1'b0, 5'd0, 32'h0,        0};
        vt[1] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    5'd0, 1'b0, 5'd0, 32'h0,        0};
        vt[2] = '{1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,    5'd5, 1'b1, 5'd5, 32'hDEADBEEF, 0};
        vt[3] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    5'd5, 1'b0, 5'd5, 32'hDEADBEEF, 0};
        vt[4] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h1234, 5'd9, 1'b0, 5'd5, 32'hDEADBEEF, 1};
        vt[5] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    5'd9, 1'b1, 5'd9, 32'h1234,     0};
        vt[6] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h55,   5'd0, 1'b0, 5'd9, 32'h1234,     0};
        vt[7] = '{1'b0, 1'b1, 5'd0, 32'h77,       1'b0, 5'd0, 32'h0,    5'd0, 1'b0, 5'd9, 32'h1234,     0};
        vt[8] = '{1'b0, 1'b1, 5'd0, 32'h77,       1'b1, 5'd4, 32'h44,   5'd4, 1'b0, 5'd9, 32'h1234,     1};
        vt[9] = '{1'b0, 1'b1, 5'd0, 32'h77,       1'b0, 5'd0, 32'h0,    5'd4, 1'b1, 5'd4, 32'h44,       0};

        ctrl_reset = 1'b1;
        bus.wb_valid = 1'b0; bus.wb_reg = '0; bus.wb_data = '0;
        bus.md_valid = 1'b0; bus.md_reg = '0; bus.md_data = '0;
        bus.rd_reg_a = '0; bus.rd_reg_b = '0;
        m_en = 1'b0; m_reg = '0; m_data = '0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 10; i++) begin
            step(vt[i].r, vt[i].wv, vt[i].wr, vt[i].wd, vt[i].mv, vt[i].mr, vt[i].md, vt[i].ra, 5'd0);
            chk($sformatf("vec%0d_en", i), 32'(bus.ctrl_writeEnable), 32'(vt[i].en));
            chk($sformatf("vec%0d_reg", i), 32'(bus.ctrl_writeReg), 32'(vt[i].wreg));
            chk($sformatf("vec%0d_data", i), bus.data_writeReg, vt[i].wdata);
            chk($sformatf("vec%0d_cnt", i), 32'(bus.queue_count), 32'(vt[i].cnt));
        end

        // fill while wb holds the port, then drain in FIFO order
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 5'(20 + i), 32'(i), 1'b1, 5'(10 + i), 32'(256 + i), 5'd10, 5'd13);
            if (i == 3) begin
                chk("fill_count", 32'(bus.queue_count), 32'd4);
                chk("fill_ready", 32'(bus.md_ready), 32'd0);
            end
        end
        idle(5'd11);
        chk("drain_first_reg", 32'(bus.ctrl_writeReg), 32'd10);
        repeat (4) idle(5'd13);
        chk("drain_empty", 32'(bus.queue_count), 32'd0);

        // squash: queued r7 is overtaken by a wb to r7
        step(1'b0, 1'b1, 5'd20, 32'h20, 1'b1, 5'd7, 32'h11, 5'd7, 5'd0);
        step(1'b0, 1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0);
        chk("squash_wr", bus.data_writeReg, 32'h22);
        idle(5'd7);
        chk("squash_dead_en", 32'(bus.ctrl_writeEnable), 32'd0);
        chk("squash_dead_cnt", 32'(bus.queue_count), 32'd0);

        // bypass picks the newest of two queued r3 writes
        step(1'b0, 1'b1, 5'd20, 32'h1, 1'b1, 5'd3, 32'hA, 5'd3, 5'd0);
        step(1'b0, 1'b1, 5'd21, 32'h2, 1'b1, 5'd3, 32'hB, 5'd3, 5'd3);
        bus.rd_reg_a = 5'd3;
        #1;
        chk("byp3_hit", 32'(bus.byp_hit_a), 32'(BYP));
        chk("byp3_data", bus.byp_data_a, BYP ? 32'hB : 32'h0);
        repeat (3) idle(5'd3);
        idle(5'd3);
        bus.rd_reg_a = 5'd3;
        #1;
        chk("byp3_gone", 32'(bus.byp_hit_a), 32'd0);

        // reset with three queued entries and a write in flight
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 5'(20 + i), 32'(i), 1'b1, 5'(1 + i), 32'hBAD0 + 32'(i), 5'd1, 5'd2);
        chk("pre_rst_cnt", 32'(bus.queue_count), 32'd3);
        chk("pre_rst_en", 32'(bus.ctrl_writeEnable), 32'd1);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd2);
        chk("rst_cnt", 32'(bus.queue_count), 32'd0);
        chk("rst_en", 32'(bus.ctrl_writeEnable), 32'd0);
        chk("rst_ready", 32'(bus.md_ready), 32'd0);
        repeat (4) idle(5'd2);
        chk("post_rst_ready", 32'(bus.md_ready), 32'd1);

        // random traffic over a small register range to provoke collisions
        for (int c = 0; c < 400; c++)
            step($urandom_range(63) == 0, $urandom_range(1) == 1, 5'($urandom_range(7)), $urandom,
                 $urandom_range(2) != 0, 5'($urandom_range(7)), $urandom,
                 5'($urandom_range(7)), 5'($urandom_range(7)));
        repeat (DEPTH + 2) idle(5'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
